// File: rtl/la_capture.sv
// Logic-analyzer probe block: memory-mapped DATA/OENB/IENA banks plus a
// capture engine feeding a FIFO, in periodic or on-change mode.
module la_capture #(
    parameter logic [31:0] BASE_ADR   = 32'h2200_0000,
    parameter int          LA_WIDTH   = 128,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                iomem_valid,
    input  logic [31:0]         iomem_addr,
    input  logic [3:0]          iomem_wstrb,
    input  logic [31:0]         iomem_wdata,
    output logic                iomem_ready,
    output logic [31:0]         iomem_rdata,
    input  logic [LA_WIDTH-1:0] la_data_in,
    output logic [LA_WIDTH-1:0] la_data,
    output logic [LA_WIDTH-1:0] la_oenb,
    output logic [LA_WIDTH-1:0] la_iena,
    output logic                irq
);
    localparam int          NW        = LA_WIDTH / 32;
    localparam int          AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [8:0]  DEPTH_CNT = 9'(FIFO_DEPTH);
    localparam logic [31:0] CTRL_MASK = 32'h00FF_0F07;
    localparam logic [7:0]  A_CTRL    = 8'hC0;
    localparam logic [7:0]  A_PERIOD  = 8'hC4;
    localparam logic [7:0]  A_STATUS  = 8'hC8;
    localparam logic [7:0]  A_FIFO    = 8'hCC;
    localparam logic [7:0]  A_SAMPLE  = 8'hD0;

    function automatic logic [31:0] wmerge(input logic [31:0] old, input logic [31:0] d,
                                           input logic [3:0] s);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = s[b] ? d[8*b +: 8] : old[8*b +: 8];
        return res;
    endfunction

    logic [7:0]  off;
    logic [3:0]  widx;
    logic        acc, is_wr, aligned;
    logic        wr_data, wr_oenb, wr_iena, wr_ctrl, wr_period, w1c, smp, clr;

    logic [31:0] ctrl_q;
    logic [15:0] period_q;
    logic [15:0] cnt_q;
    logic [31:0] last_q;
    logic        overflow_q;
    logic [31:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [8:0]  count_q;

    logic        cap_en, mode, irq_en;
    logic [3:0]  sel;
    logic [7:0]  thresh;
    logic        full, empty, per_hit, chg_hit, push_req, push, pop, drop;
    logic [31:0] cap_word, rd_word, status;

    assign off     = iomem_addr[7:0];
    assign widx    = off[5:2];
    assign aligned = (off[1:0] == 2'b00);
    assign acc     = iomem_valid && !iomem_ready && (iomem_addr[31:8] == BASE_ADR[31:8]);
    assign is_wr   = |iomem_wstrb;

    assign wr_data   = acc && is_wr && aligned && (off[7:6] == 2'b00);
    assign wr_oenb   = acc && is_wr && aligned && (off[7:6] == 2'b01);
    assign wr_iena   = acc && is_wr && aligned && (off[7:6] == 2'b10);
    assign wr_ctrl   = acc && is_wr && (off == A_CTRL);
    assign wr_period = acc && is_wr && (off == A_PERIOD);
    assign w1c       = acc && is_wr && (off == A_STATUS) && iomem_wstrb[1] && iomem_wdata[11];
    assign smp       = acc && (off == A_SAMPLE);
    assign clr       = wr_ctrl && iomem_wstrb[0] && iomem_wdata[3];

    assign cap_en = ctrl_q[0];
    assign mode   = ctrl_q[1];
    assign irq_en = ctrl_q[2];
    assign sel    = ctrl_q[11:8];
    assign thresh = ctrl_q[23:16];

    assign full   = (count_q == DEPTH_CNT);
    assign empty  = (count_q == 9'd0);
    assign status = {20'h0, overflow_q, full, empty, count_q};

    // Out-of-range sel leaves the capture word at zero.
    always_comb begin
        cap_word = '0;
        for (int k = 0; k < NW; k++)
            if (sel == 4'(k))
                cap_word = la_data_in[32*k +: 32] & la_oenb[32*k +: 32] & la_iena[32*k +: 32];
    end

    assign per_hit  = cap_en && !mode && (cnt_q == period_q);
    assign chg_hit  = cap_en && mode && (cap_word != last_q);
    assign push_req = per_hit || chg_hit;
    assign pop      = acc && !is_wr && (off == A_FIFO) && !empty;
    assign push     = push_req && (!full || pop) && !clr;
    assign drop     = push_req && full && !pop && !clr;

    always_comb begin
        rd_word = '0;
        if (aligned && off[7:6] != 2'b11) begin
            for (int k = 0; k < NW; k++) begin
                if (widx == 4'(k)) begin
                    unique case (off[7:6])
                        2'b00:   rd_word = la_data_in[32*k +: 32];
                        2'b01:   rd_word = la_oenb[32*k +: 32];
                        default: rd_word = la_iena[32*k +: 32];
                    endcase
                end
            end
        end else begin
            unique case (off)
                A_CTRL:   rd_word = ctrl_q;
                A_PERIOD: rd_word = {16'h0, period_q};
                A_STATUS: rd_word = status;
                A_FIFO:   rd_word = empty ? 32'h0 : mem[rd_ptr];
                default:  rd_word = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= cap_word;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            la_data     <= '0;
            la_oenb     <= '1;
            la_iena     <= '0;
            ctrl_q      <= '0;
            period_q    <= '0;
            cnt_q       <= '0;
            last_q      <= '0;
            overflow_q  <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            irq         <= 1'b0;
        end else begin
            iomem_ready <= acc;
            if (acc)
                iomem_rdata <= is_wr ? 32'h0 : rd_word;

            for (int k = 0; k < NW; k++) begin
                if (smp)
                    la_data[32*k +: 32] <= la_data_in[32*k +: 32] & la_oenb[32*k +: 32]
                                           & la_iena[32*k +: 32];
                else if (wr_data && widx == 4'(k))
                    la_data[32*k +: 32] <= wmerge(la_data[32*k +: 32], iomem_wdata, iomem_wstrb);
                if (wr_oenb && widx == 4'(k))
                    la_oenb[32*k +: 32] <= wmerge(la_oenb[32*k +: 32], iomem_wdata, iomem_wstrb);
                if (wr_iena && widx == 4'(k))
                    la_iena[32*k +: 32] <= wmerge(la_iena[32*k +: 32], iomem_wdata, iomem_wstrb);
            end

            if (wr_ctrl)
                ctrl_q <= wmerge(ctrl_q, iomem_wdata, iomem_wstrb) & CTRL_MASK;
            if (wr_period && iomem_wstrb[0])
                period_q[7:0] <= iomem_wdata[7:0];
            if (wr_period && iomem_wstrb[1])
                period_q[15:8] <= iomem_wdata[15:8];

            if (clr || !cap_en || mode || cnt_q == period_q)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + 16'd1;

            last_q <= cap_word;

            // Clear wins over everything, and a drop wins over a same-cycle W1C.
            if (clr) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count_q    <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                unique case ({push, pop})
                    2'b10:   count_q <= count_q + 9'd1;
                    2'b01:   count_q <= count_q - 9'd1;
                    default: count_q <= count_q;
                endcase
                if (drop)
                    overflow_q <= 1'b1;
                else if (w1c)
                    overflow_q <= 1'b0;
            end

            irq <= irq_en && (overflow_q || (count_q >= {1'b0, thresh} && thresh != 8'd0));
        end
    end
endmodule

// File: tb/tb_la_capture.sv
// Bench for la_capture: register vector table, then capture-engine sequences
// with a queue holding the samples each FIFO read should return.
module tb_la_capture;
    localparam int          LAW  = 64;
    localparam logic [31:0] BASE = 32'h2200_0000;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           valid = 1'b0;
    logic [31:0]    addr = '0;
    logic [3:0]     wstrb = '0;
    logic [31:0]    wdata = '0;
    logic           ready;
    logic [31:0]    rdata;
    logic [LAW-1:0] la_in = '0;
    logic [LAW-1:0] la_data, la_oenb, la_iena;
    logic           irq;

    la_capture #(.BASE_ADR(BASE), .LA_WIDTH(LAW), .FIFO_DEPTH(4)) dut (
        .clk(clk), .resetn(resetn),
        .iomem_valid(valid), .iomem_addr(addr), .iomem_wstrb(wstrb), .iomem_wdata(wdata),
        .iomem_ready(ready), .iomem_rdata(rdata),
        .la_data_in(la_in), .la_data(la_data), .la_oenb(la_oenb), .la_iena(la_iena),
        .irq(irq)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] sb[$];

    typedef struct {
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        logic        rdy;
        logic        chk;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[25];

    function automatic logic [31:0] A(input logic [7:0] o);
        return {BASE[31:8], o};
    endfunction

    function automatic logic [31:0] stat(input int c, input logic ov);
        return {20'h0, ov, (c == 4), (c == 0), 9'(c)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] r, output logic ok);
        ok = 1'b0;
        r  = '0;
        @(negedge clk);
        valid = 1'b1; addr = a; wstrb = s; wdata = d;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(posedge clk); #1;
            if (ready) begin ok = 1'b1; r = rdata; end
        end
        valid = 1'b0;
        wstrb = 4'h0;
    endtask

    task automatic wrs(input logic [7:0] o, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] r;
        logic ok;
        bus(A(o), s, d, r, ok);
        check($sformatf("ack_wr_%h", o), ok, 1);
    endtask

    task automatic wr(input logic [7:0] o, input logic [31:0] d);
        wrs(o, 4'hF, d);
    endtask

    task automatic rd(input logic [7:0] o, input logic [31:0] exp, input string name);
        logic [31:0] r;
        logic ok;
        bus(A(o), 4'h0, 32'h0, r, ok);
        check({name, "_ack"}, ok, 1);
        check(name, r, exp);
    endtask

    task automatic fifo_rd();
        logic [31:0] e;
        e = (sb.size() > 0) ? sb.pop_front() : 32'h0;
        rd(8'hCC, e, "fifo");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic ok;

        la_in = 64'h1234_5678_9ABC_DEF0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready, 0);
        check("rst_rdata", rdata, 0);
        check("rst_la_data", la_data, 0);
        check("rst_la_oenb", la_oenb, {LAW{1'b1}});
        check("rst_la_iena", la_iena, 0);
        check("rst_irq", irq, 0);
        @(negedge clk);
        resetn = 1'b1;

        vt[0]  = '{A(8'hC8), 4'h0, 32'h0,         1'b1, 1'b1, 32'h0000_0200};
        vt[1]  = '{A(8'hC0), 4'h0, 32'h0,         1'b1, 1'b1, 32'h0};
        vt[2]  = '{A(8'hC4), 4'h0, 32'h0,         1'b1, 1'b1, 32'h0};
        vt[3]  = '{A(8'h40), 4'h0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFF};
        vt[4]  = '{A(8'h84), 4'h0, 32'h0,         1'b1, 1'b1, 32'h0};
        vt[5]  = '{A(8'h00), 4'h0, 32'h0,         1'b1, 1'b1, 32'h9ABC_DEF0};
        vt[6]  = '{A(8'h04), 4'h0, 32'h0,         1'b1, 1'b1, 32'h1234_5678};
        vt[7]  = '{A(8'hC4), 4'hF, 32'hABCD_1234, 1'b1, 1'b0, 32'h0};
        vt[8]  = '{A(8'hC4), 4'h0, 32'h0,         1'b1, 1'b1, 32'h0000_1234};
        vt[9]  = '{A(8'hC4), 4'h2, 32'h0000_5600, 1'b1, 1'b0, 32'h0};
        vt[10] = '{A(8'hC4), 4'h0, 32'h0,         1'b1, 1'b1, 32'h0000_5634};
        vt[11] = '{A(8'hC0), 4'h4, 32'h00AA_0000, 1'b1, 1'b0, 32'h0};
        vt[12] = '{A(8'hC0), 4'h3, 32'h0000_0F0E, 1'b1, 1'b0, 32'h0};
        vt[13] = '{A(8'hC0), 4'h0, 32'h0,         1'b1, 1'b1, 32'h00AA_0F06};
        vt[14] = '{A(8'hC0), 4'hF, 32'h0,         1'b1, 1'b0, 32'h0};
        vt[15] = '{A(8'h44), 4'h1, 32'h0000_0012, 1'b1, 1'b0, 32'h0};
        vt[16] = '{A(8'h44), 4'h0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FF12};
        vt[17] = '{A(8'hF0), 4'h0, 32'h0,         1'b1, 1'b1, 32'h0};
        vt[18] = '{A(8'h08), 4'h0, 32'h0,         1'b1, 1'b1, 32'h0};
        vt[19] = '{32'h2300_0000, 4'h0, 32'h0,    1'b0, 1'b0, 32'h0};
        vt[20] = '{32'h2200_0100, 4'h0, 32'h0,    1'b0, 1'b0, 32'h0};
        vt[21] = '{A(8'hCC), 4'hF, 32'h0000_1234, 1'b1, 1'b0, 32'h0};
        vt[22] = '{A(8'hC8), 4'h0, 32'h0,         1'b1, 1'b1, 32'h0000_0200};
        vt[23] = '{A(8'h88), 4'hF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0};
        vt[24] = '{A(8'h80), 4'h0, 32'h0,         1'b1, 1'b1, 32'h0};

        for (int i = 0; i < 25; i++) begin
            bus(vt[i].a, vt[i].s, vt[i].d, r, ok);
            check($sformatf("vec%0d_ready", i), ok, vt[i].rdy);
            if (vt[i].chk) check($sformatf("vec%0d_rdata", i), r, vt[i].exp);
        end
        check("tab_la_oenb", la_oenb, {32'hFFFF_FF12, 32'hFFFF_FFFF});
        check("tab_la_iena", la_iena, 0);

        // Periodic capture with mask word 0 cleared: pushes of zero every 4 cycles.
        la_in = {32'h1234_5678, 32'hA5A5_0F0F};
        wr(8'h40, 32'h0);
        wr(8'h80, 32'hFFFF_FFFF);
        wr(8'hC4, 32'd3);
        wr(8'hC0, 32'h1);
        rd(8'hC8, stat(0, 0), "per_st0");
        rd(8'hC8, stat(0, 0), "per_st1");
        rd(8'hC8, stat(1, 0), "per_st2");
        rd(8'hC8, stat(1, 0), "per_st3");
        rd(8'hC8, stat(2, 0), "per_st4");
        rd(8'hC8, stat(2, 0), "per_st5");
        rd(8'hC8, stat(3, 0), "per_st6");
        wr(8'hC0, 32'h0);
        repeat (4) sb.push_back(32'h0);
        rd(8'hC8, stat(4, 0), "per_full");
        repeat (4) fifo_rd();
        rd(8'hCC, 32'h0, "fifo_empty_rd");
        rd(8'hC8, stat(0, 0), "per_drained");

        wr(8'h40, 32'hFFFF_FFFF);
        wr(8'hC0, 32'h9);
        rd(8'hC8, stat(0, 0), "per2_st0");
        rd(8'hC8, stat(0, 0), "per2_st1");
        rd(8'hC8, stat(1, 0), "per2_st2");
        wr(8'hC0, 32'h0);
        repeat (2) sb.push_back(32'hA5A5_0F0F);
        rd(8'hC8, stat(2, 0), "per2_cnt");
        repeat (2) fifo_rd();

        // On-change capture: three input changes produce three ordered entries.
        la_in[31:0] = 32'h1111_1111;
        wr(8'hC0, 32'h3);
        repeat (2) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            la_in[31:0] = 32'h2222_2222 * (i + 1);
            sb.push_back(la_in[31:0]);
            repeat (3) @(posedge clk);
        end
        wr(8'hC0, 32'h0);
        rd(8'hC8, stat(3, 0), "chg_cnt");
        repeat (3) fifo_rd();
        rd(8'hC8, stat(0, 0), "chg_drained");

        // PERIOD=0 fills the 4-deep FIFO and overflows; irq follows overflow.
        la_in[31:0] = 32'h4444_4444;
        wr(8'hC4, 32'h0);
        wr(8'hC0, 32'h5);
        repeat (4) sb.push_back(32'h4444_4444);
        repeat (10) @(posedge clk);
        rd(8'hC8, stat(4, 1), "ovf_status");
        check("ovf_irq", irq, 1);
        wr(8'hC0, 32'h4);
        wrs(8'hC8, 4'h2, 32'h0000_0800);
        rd(8'hC8, stat(4, 0), "w1c_status");
        check("w1c_irq", irq, 0);
        wr(8'hC0, 32'h0004_0004);
        @(posedge clk); #1;
        check("thresh_eq_irq", irq, 1);
        wr(8'hC0, 32'h0005_0004);
        @(posedge clk); #1;
        check("thresh_above_irq", irq, 0);
        wr(8'hC0, 32'h0004_0000);
        @(posedge clk); #1;
        check("irq_en_off", irq, 0);

        // Full FIFO: pops coinciding with PERIOD=1 pushes keep count at 4.
        la_in[31:0] = 32'h5555_5555;
        wr(8'hC4, 32'd1);
        wr(8'hC0, 32'h1);
        repeat (2) sb.push_back(32'h5555_5555);
        fifo_rd();
        fifo_rd();
        rd(8'hC8, stat(4, 0), "popush_status");
        wr(8'hC0, 32'h0);
        rd(8'hC8, stat(4, 1), "drop_status");
        wrs(8'hC8, 4'h2, 32'h0000_0800);
        rd(8'hC8, stat(4, 0), "drop_w1c");
        repeat (4) fifo_rd();
        rd(8'hC8, stat(0, 0), "popush_drained");

        // Clear empties FIFO, clears overflow and discards its own-cycle push.
        wr(8'hC4, 32'h0);
        wr(8'hC0, 32'h1);
        repeat (8) @(posedge clk);
        wr(8'hC0, 32'h8);
        rd(8'hC8, stat(0, 0), "clr_status");
        rd(8'hC0, 32'h0, "clr_reads0");
        wr(8'hC0, 32'h1);
        wr(8'hC0, 32'h8);
        rd(8'hC8, stat(0, 0), "clr_discard");

        // sel beyond NW captures zero.
        wr(8'hC0, 32'h0000_0201);
        wr(8'hC0, 32'h0);
        repeat (2) sb.push_back(32'h0);
        rd(8'hC8, stat(2, 0), "sel_hi_cnt");
        repeat (2) fifo_rd();

        // DATA writes and SAMPLE snapshot.
        la_in = 64'h1234_5678_9ABC_DEF0;
        wr(8'h40, 32'h0);
        wr(8'h44, 32'h0000_FFFF);
        wr(8'h84, 32'hFFFF_FFFF);
        wr(8'h00, 32'hDEAD_BEEF);
        wrs(8'h04, 4'h8, 32'hAB00_0000);
        check("data_wr", la_data, {32'hAB00_0000, 32'hDEAD_BEEF});
        check("oenb_set", la_oenb, {32'h0000_FFFF, 32'h0});
        check("iena_set", la_iena, {LAW{1'b1}});
        rd(8'hD0, 32'h0, "sample_rd");
        check("sample_la_data", la_data, {32'h0000_5678, 32'h0});

        // Reset asserted during an access suppresses the ack.
        @(negedge clk);
        valid = 1'b1; addr = A(8'hC8); wstrb = 4'h0; resetn = 1'b0;
        @(posedge clk); #1;
        check("rst_acc_noack", ready, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        check("reissue_ack", ready, 1);
        check("reissue_rdata", rdata, 32'h0000_0200);
        valid = 1'b0;
        check("rst2_la_data", la_data, 0);
        check("rst2_la_oenb", la_oenb, {LAW{1'b1}});
        check("rst2_irq", irq, 0);
        rd(8'hC4, 32'h0, "rst2_period");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
